// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes on input and output; single-entry output register.
// Define ALU_PIPE_MUL_EN to get the iterative shift-add multiplier for opcode 111 (otherwise it yields 0).
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUControl,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic             OverFlow,
  output logic             Carry,
  output logic             Zero,
  output logic             Negative
);

  logic             idle;
  logic             outFree;
  logic             accept;
  logic             loadAlu;
  logic             loadMul;
  logic [WIDTH-1:0] mulRes;
  logic             mulCarry;

  logic [WIDTH-1:0] bOp;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] aluRes;
  logic             aluOv;
  logic             aluCarry;

  assign outFree = !OutValid || OutReady;
  assign InReady = idle && outFree;
  assign accept  = InValid && InReady;

  // SUB is A + ~B + 1, so Carry doubles as the unsigned "no borrow" flag.
  always_comb begin
    bOp      = (ALUControl == 3'b001) ? ~B : B;
    sum      = {1'b0, A} + {1'b0, bOp} + {{WIDTH{1'b0}}, (ALUControl == 3'b001)};
    aluRes   = '0;
    aluOv    = 1'b0;
    aluCarry = 1'b0;
    case (ALUControl)
      3'b000, 3'b001: begin
        aluRes   = sum[WIDTH-1:0];
        aluCarry = sum[WIDTH];
        aluOv    = (A[WIDTH-1] == bOp[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      3'b010:  aluRes = A & B;
      3'b011:  aluRes = A | B;
      3'b100:  aluRes = A ^ B;
      3'b101:  aluRes = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      3'b110:  aluRes = {{(WIDTH-1){1'b0}}, (A < B)};
      default: aluRes = '0;
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, LOAD} state_t;

  state_t               state;
  state_t               nextState;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     mplier;
  logic [CW-1:0]        count;
  logic                 isMul;

  assign isMul    = (ALUControl == 3'b111);
  assign idle     = (state == IDLE);
  assign loadAlu  = accept && !isMul;
  assign loadMul  = (state == LOAD) && outFree;
  assign mulRes   = prod[WIDTH-1:0];
  assign mulCarry = |prod[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept && isMul) nextState = MUL;
      MUL:     if (count == CW'(1)) nextState = LOAD;
      LOAD:    if (outFree) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // One shift-add step per cycle; the product is complete after WIDTH steps.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      prod   <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (state == IDLE) begin
      if (accept && isMul) begin
        mcand  <= {{WIDTH{1'b0}}, A};
        prod   <= '0;
        mplier <= B;
        count  <= CW'(WIDTH);
      end
    end else if (state == MUL) begin
      if (mplier[0]) prod <= prod + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - CW'(1);
    end
  end
`else
  assign idle     = 1'b1;
  assign loadAlu  = accept;
  assign loadMul  = 1'b0;
  assign mulRes   = '0;
  assign mulCarry = 1'b0;
`endif

  // Output register only changes when a result loads; otherwise it holds under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      OutValid <= 1'b0;
      Result   <= '0;
      OverFlow <= 1'b0;
      Carry    <= 1'b0;
      Zero     <= 1'b0;
      Negative <= 1'b0;
    end else if (loadAlu) begin
      OutValid <= 1'b1;
      Result   <= aluRes;
      OverFlow <= aluOv;
      Carry    <= aluCarry;
      Zero     <= (aluRes == '0);
      Negative <= aluRes[WIDTH-1];
    end else if (loadMul) begin
      OutValid <= 1'b1;
      Result   <= mulRes;
      OverFlow <= 1'b0;
      Carry    <= mulCarry;
      Zero     <= (mulRes == '0);
      Negative <= mulRes[WIDTH-1];
    end else if (OutReady) begin
      OutValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: a 32-bit and an 8-bit instance checked against an arithmetic reference model.
// Honours ALU_PIPE_MUL_EN the same way the design does.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst;

  logic        inValid, inReady, outValid, outReady;
  logic [31:0] opA, opB, result;
  logic [2:0]  opCode;
  logic        overFlow, carry, zero, negative;

  logic        inValid8, inReady8, outValid8, outReady8;
  logic [7:0]  a8, b8, result8;
  logic [2:0]  op8;
  logic        overFlow8, carry8, zero8, negative8;

  int          vectors = 0;
  int          miscompares = 0;
  bit          randomReady = 1'b0;
  logic [35:0] q32[$];
  logic [35:0] q8[$];
  logic [35:0] exp32, exp8;

  alu_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .InValid(inValid), .InReady(inReady),
    .A(opA), .B(opB), .ALUControl(opCode), .OutValid(outValid), .OutReady(outReady),
    .Result(result), .OverFlow(overFlow), .Carry(carry), .Zero(zero), .Negative(negative)
  );

  alu_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .InValid(inValid8), .InReady(inReady8),
    .A(a8), .B(b8), .ALUControl(op8), .OutValid(outValid8), .OutReady(outReady8),
    .Result(result8), .OverFlow(overFlow8), .Carry(carry8), .Zero(zero8), .Negative(negative8)
  );

  always #5 clk = ~clk;

`ifdef ALU_PIPE_MUL_EN
  localparam int MUL_LAT32 = 33;
  localparam int MUL_LAT8  = 9;
`else
  localparam int MUL_LAT32 = 0;
  localparam int MUL_LAT8  = 0;
`endif

  // Reference: plain integer arithmetic on w-bit values; packs {OverFlow, Carry, Zero, Negative, Result}.
  function automatic logic [35:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input int w);
    logic [63:0] m, ua, ub, r, p;
    longint      half, full, sa, sb, sr;
    logic        c, v;
    m    = (64'd1 << w) - 64'd1;
    ua   = {32'd0, a} & m;
    ub   = {32'd0, b} & m;
    half = longint'(1) << (w - 1);
    full = longint'(1) << w;
    sa   = longint'(ua);
    sb   = longint'(ub);
    if (sa >= half) sa = sa - full;
    if (sb >= half) sb = sb - full;
    r = 64'd0; c = 1'b0; v = 1'b0; p = 64'd0; sr = 0;
    case (op)
      3'd0: begin sr = sa + sb; r = (ua + ub) & m; c = (ua + ub) > m; v = (sr < -half) || (sr >= half); end
      3'd1: begin sr = sa - sb; r = (ua - ub) & m; c = (ua >= ub);    v = (sr < -half) || (sr >= half); end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = (sa < sb) ? 64'd1 : 64'd0;
      3'd6: r = (ua < ub) ? 64'd1 : 64'd0;
      default: begin
`ifdef ALU_PIPE_MUL_EN
        p = ua * ub;
        r = p & m;
        c = (p >> w) != 64'd0;
`endif
      end
    endcase
    return {v, c, (r == 64'd0), r[w-1], r[31:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [35:0] act, input logic [35:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present one op to the chosen instance and push its expectation once the transfer is certain.
  task automatic applyStimulus(input bit sel, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit done = 1'b0;
    int waited = 0;
    if (!sel) begin inValid = 1'b1; opA = a; opB = b; opCode = op; end
    else begin inValid8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; op8 = op; end
    while (!done) begin
      @(negedge clk);
      if (!sel && inReady) begin q32.push_back(model(op, a, b, 32)); done = 1'b1; end
      else if (sel && inReady8) begin q8.push_back(model(op, a, b, 8)); done = 1'b1; end
      else if (waited++ > 200) begin
        checkOutput("acceptTimeout", 36'd0, 36'd1);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    inValid = 1'b0; inValid8 = 1'b0;
    opA = $urandom; opB = $urandom; opCode = 3'($urandom);
    a8 = 8'($urandom); b8 = 8'($urandom); op8 = 3'($urandom);
  endtask

  // Edges from acceptance until OutValid shows (0 means registered on the acceptance edge).
  task automatic checkLatency(input bit sel, input string name, input int expected);
    int lat = 0;
    while (!(sel ? outValid8 : outValid) && lat < 200) begin @(posedge clk); #1; lat++; end
    checkOutput(name, 36'(lat), 36'(expected));
  endtask

  always @(posedge clk) begin
    #1;
    if (randomReady) begin
      outReady  = ($urandom_range(0, 3) != 0);
      outReady8 = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitors: the head of each queue must be on the outputs for every cycle OutValid is high.
  always @(negedge clk) begin
    if (!rst && outValid) begin
      if (q32.size() == 0) checkOutput("out32Unexpected", {overFlow, carry, zero, negative, result}, 36'hx);
      else begin
        exp32 = q32[0];
        checkOutput("out32", {overFlow, carry, zero, negative, result}, exp32);
        if (outReady) void'(q32.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && outValid8) begin
      if (q8.size() == 0) checkOutput("out8Unexpected", {overFlow8, carry8, zero8, negative8, 24'd0, result8}, 36'hx);
      else begin
        exp8 = q8[0];
        checkOutput("out8", {overFlow8, carry8, zero8, negative8, 24'd0, result8},
                    {exp8[35:32], 24'd0, exp8[7:0]});
        if (outReady8) void'(q8.pop_front());
      end
    end
  end

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int guard;
    rst = 1'b1; inValid = 1'b0; inValid8 = 1'b0;
    opA = '0; opB = '0; opCode = '0; a8 = '0; b8 = '0; op8 = '0;
    outReady = 1'b1; outReady8 = 1'b1;
    idle(2);
    checkOutput("resetOutputs", {outValid, overFlow, carry, zero, negative, result}, 36'd0);
    rst = 1'b0;
    idle(1);
    checkOutput("resetInReady", {35'd0, inReady}, 36'd1);

    applyStimulus(0, 3'b000, 32'h7FFF_FFFF, 32'h0000_0001);
    applyStimulus(0, 3'b000, 32'hFFFF_FFFF, 32'h0000_0001);
    applyStimulus(0, 3'b001, 32'h0000_0010, 32'h0000_0010);
    applyStimulus(0, 3'b001, 32'h0000_0000, 32'h0000_0001);

    applyStimulus(0, 3'b010, 32'hFFFF_FFFF, 32'h0000_FFFF);
    applyStimulus(0, 3'b011, 32'hFFFF_0000, 32'h0000_FFFF);
    applyStimulus(0, 3'b101, 32'h0000_0005, 32'h0000_0010);
    applyStimulus(0, 3'b110, 32'hFFFF_FFFF, 32'h0000_0001);
    idle(2);

    outReady = 1'b0;
    applyStimulus(0, 3'b000, 32'h0000_0001, 32'h0000_0002);
    repeat (3) begin
      idle(1);
      checkOutput("bpHold", {overFlow, carry, zero, negative, result}, model(3'b000, 32'd1, 32'd2, 32));
      checkOutput("bpInReady", {35'd0, inReady}, 36'd0);
    end
    outReady = 1'b1;
    applyStimulus(0, 3'b100, 32'hF0F0_F0F0, 32'hFFFF_FFFF);
    checkOutput("bpDrainLoad", {overFlow, carry, zero, negative, result}, {4'b0000, 32'h0F0F_0F0F});
    idle(2);

    applyStimulus(0, 3'b111, 32'h0001_0000, 32'h0001_0000);
    checkLatency(0, "mulLatency32", MUL_LAT32);
    applyStimulus(0, 3'b111, 32'd7, 32'd6);
    checkLatency(0, "mulLatency32b", MUL_LAT32);
    idle(2);

    applyStimulus(1, 3'b000, 32'h7F, 32'h01);
    applyStimulus(1, 3'b001, 32'h00, 32'h01);
    idle(2);
    applyStimulus(1, 3'b111, 32'h10, 32'h10);
    checkLatency(1, "op111Latency8", MUL_LAT8);
    idle(2);

`ifdef ALU_PIPE_MUL_EN
    begin
      bit seen = 1'b0;
      applyStimulus(0, 3'b111, 32'd123, 32'd456);
      idle(5);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      q32.delete();
      repeat (40) begin idle(1); if (outValid) seen = 1'b1; end
      checkOutput("mulAbort", {35'd0, seen}, 36'd0);
    end
`endif

    outReady = 1'b0;
    applyStimulus(0, 3'b000, 32'd10, 32'd20);
    applyStimulus(1, 3'b011, 32'h0F, 32'hF0);
    rst = 1'b1;
    idle(2);
    q32.delete(); q8.delete();
    checkOutput("midResetOutputs", {outValid, overFlow, carry, zero, negative, result}, 36'd0);
    checkOutput("midResetOutputs8", {outValid8, overFlow8, carry8, zero8, negative8, 23'd0, result8}, 36'd0);
    rst = 1'b0;
    outReady = 1'b1;
    idle(1);
    checkOutput("midResetInReady", {34'd0, inReady8, inReady}, 36'd3);

    randomReady = 1'b1;
    repeat (250) begin
      applyStimulus(0, 3'($urandom_range(0, 7)), pickOperand(), pickOperand());
      idle($urandom_range(0, 2));
    end
    repeat (120) begin
      applyStimulus(1, 3'($urandom_range(0, 7)), pickOperand(), pickOperand());
      idle($urandom_range(0, 1));
    end

    randomReady = 1'b0;
    idle(1);
    outReady = 1'b1; outReady8 = 1'b1;
    guard = 0;
    while ((q32.size() != 0 || q8.size() != 0) && guard < 500) begin idle(1); guard++; end
    checkOutput("drain", 36'(q32.size() + q8.size()), 36'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the combinational 32-bit ALU, with a valid/ready handshake on both input and output.
- Executes the existing 3-bit opcode set plus XOR, unsigned compare, and an iterative shift-add multiply.
- Sits between operand fetch and writeback in the datapath.
- Produces the existing flags (OverFlow, Carry, Zero, Negative) per result.

Parameters:
- WIDTH, 32: operand/result width in bits; must be >= 2.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- InValid  in  1  operand/opcode presented.
- InReady  out  1  block can accept; transfer when InValid && InReady at a rising edge.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- ALUControl  in  3  opcode.
- OutValid  out  1  Result/flags valid.
- OutReady  in  1  consumer accepts; transfer when OutValid && OutReady at a rising edge.
- Result  out  WIDTH  registered result.
- OverFlow  out  1  signed overflow.
- Carry  out  1  carry / no-borrow / multiply high-part nonzero.
- Zero  out  1  Result == 0.
- Negative  out  1  Result[WIDTH-1].

Behaviour:
- Reset: while rst is high at an edge, all outputs are 0, OutValid=0, FSM=IDLE, and any multiply in progress is aborted and discarded. InReady is 1 the cycle after reset deasserts.
- Opcodes:
  - 000 ADD: A+B.
  - 001 SUB: A+~B+1.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SLT: signed A<B → Result = {WIDTH-1 zeros, lt}.
  - 110 SLTU: unsigned A<B, same format as SLT.
  - 111 MUL: low WIDTH bits of unsigned A*B.
- Flags:
  - ADD/SUB: Carry = bit WIDTH of the (WIDTH+1)-bit sum. For SUB, Carry=1 means A>=B unsigned, so 0-0 gives Carry=1.
  - ADD/SUB: OverFlow = signed overflow (operand signs equal, after inverting B for SUB, and result sign differs).
  - Logic/SLT/SLTU: Carry=0, OverFlow=0.
  - MUL: Carry=1 iff the upper WIDTH bits of the full 2*WIDTH product are nonzero; OverFlow=0.
  - All ops: Zero and Negative are derived from Result.
- Output register:
  - One entry. Result/flags change only when a new result is loaded.
  - Values are held stable while OutValid && !OutReady.
  - OutValid clears on output transfer unless a new result loads in the same edge.
- InReady = (FSM==IDLE) && (!OutValid || OutReady). Accepting a new op in the same edge as the output drains is allowed: full throughput, one op per cycle.
- Single-cycle ops: accepted at edge k → result registered at edge k, OutValid high from cycle k+1.
- FSM states: IDLE, MUL, LOAD.
  - IDLE → MUL: on acceptance of opcode 111. Latch A as multiplicand (2*WIDTH bits), B as multiplier, product=0, counter=WIDTH.
  - MUL: each edge, if multiplier[0] then add multiplicand to product; shift multiplicand left, multiplier right; decrement counter. After the WIDTH-th step → LOAD.
  - LOAD: write product and flags to the output register when !OutValid || OutReady; otherwise stay in LOAD (stall) → IDLE.
  - Unstalled MUL: accepted at edge k, OutValid high from cycle k+WIDTH+2.
- InReady=0 throughout MUL and LOAD. A/B/ALUControl changes during that time are ignored.
- Inputs with InValid=0 never alter state.
- rst asserted in any FSM state → IDLE next cycle; OutValid=0 regardless of OutReady.

Optional Feature:
- Macro ALU_PIPE_MUL_EN.
- Defined: opcode 111 is the iterative MUL above, with the MUL and LOAD states present.
- Undefined: no multiplier datapath or MUL/LOAD states. Opcode 111 completes as a single-cycle op with Result=0, Zero=1, Carry=0, OverFlow=0, Negative=0.

Test Plan:
- Reset: hold rst 2 cycles mid-stream → all outputs 0, OutValid=0; InReady=1 the cycle after release.
- ADD/SUB at WIDTH=32, OutReady=1:
  - 0x7FFFFFFF+1 → Result 0x80000000, OverFlow=1, Negative=1, Carry=0.
  - 0xFFFFFFFF+1 → Result 0, Carry=1, Zero=1.
  - 0x10-0x10 → Result 0, Zero=1, Carry=1.
- Back-to-back: AND 0xFFFFFFFF&0x0000FFFF, then OR, then SLT 5<0x10, then SLTU 0xFFFFFFFF<1 on consecutive cycles with OutReady=1 → results 0x0000FFFF, 0xFFFFFFFF, 1, 0 on consecutive cycles.
- Backpressure: OutReady=0 for 3 cycles after an ADD → Result held constant, InReady=0; drain with OutReady=1 plus a new XOR 0xF0F0F0F0^0xFFFFFFFF in the same edge → next Result 0x0F0F0F0F.
- MUL with ALU_PIPE_MUL_EN at WIDTH=32:
  - 0x10000*0x10000 → Result 0, Carry=1, Zero=1, OutValid exactly WIDTH+2 cycles after acceptance.
  - 7*6 → 42, Carry=0.
  - rst asserted mid-multiply → no output produced.
- WIDTH=8 build without ALU_PIPE_MUL_EN:
  - 0x7F+0x01 → 0x80, OverFlow=1.
  - Opcode 111 → Result 0, Zero=1, one-cycle latency.
